// File: rtl/redirect_flush_ctrl.sv
// redirect_flush_ctrl: PC redirect, IF/ID + ID/EX flush/hold sequencing and redirect counter.
module redirect_flush_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall_req,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            busy,
  output logic [15:0]     redirect_cnt
);
  typedef enum logic [1:0] {RUN, REDIRECT, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [2:0]        drain_q, drain_d;
  logic [XLEN-1:0]   pc_target_q, pc_target_d;
  logic [15:0]       redirect_cnt_q, redirect_cnt_d;
  logic              stall;
  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    pc_target_d    = pc_target_q;
    redirect_cnt_d = redirect_cnt_q;
    case (state_q)
      RUN: if (redirect_valid) begin
        state_d        = REDIRECT;
        pc_target_d    = redirect_target;
        redirect_cnt_d = redirect_cnt_q + {15'd0, redirect_cnt_q != 16'hFFFF};
      end
      REDIRECT: begin
        state_d = (FLUSH_CYCLES == 1) ? RUN : DRAIN;
        drain_d = 3'(FLUSH_CYCLES - 1);
      end
      DRAIN: begin
        drain_d = drain_q - 3'd1;
        if (drain_q == 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      drain_q        <= 3'd0;
      pc_target_q    <= '0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      pc_target_q    <= pc_target_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end
  // a redirect in the same cycle makes the stalled instruction wrong-path, so the stall is dropped
  assign stall        = (state_q == RUN) && !redirect_valid && stall_req;
  assign pc_redirect  = state_q == REDIRECT;
  assign pc_hold      = stall;
  assign ifid_hold    = stall;
  assign ifid_flush   = state_q != RUN;
  assign idex_flush   = (state_q == REDIRECT) || stall;
  assign busy         = state_q != RUN;
  assign pc_target    = pc_target_q;
  assign redirect_cnt = redirect_cnt_q;
endmodule

// File: tb/tb_redirect_flush_ctrl.sv
// tb_redirect_flush_ctrl: directed + random stimulus against a bubble-window reference model.
module tb_redirect_flush_ctrl;
  localparam int FC = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        stall_req = 1'b0;
  logic        pc_redirect, pc_hold, ifid_hold, ifid_flush, idex_flush, busy;
  logic [31:0] pc_target;
  logic [15:0] redirect_cnt;
  int          checks = 0;
  int          errors = 0;
  int          rem = 0;
  logic [31:0] mtgt = '0;
  int          mcnt = 0;

  redirect_flush_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall_req(stall_req),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .busy(busy), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [5:0] e;
    logic       f, h;
    if (rem > 0) begin
      f = (rem == FC);
      e = {f, 1'b0, 1'b0, 1'b1, f, 1'b1};
    end else begin
      h = stall_req && !redirect_valid;
      e = {1'b0, h, h, 1'b0, h, 1'b0};
    end
    chk("ctl", 32'({pc_redirect, pc_hold, ifid_hold, ifid_flush, idex_flush, busy}), 32'(e));
    chk("target", pc_target, mtgt);
    chk("cnt", 32'(redirect_cnt), 32'(mcnt));
    chk("hold_flush_excl", 32'(ifid_hold & ifid_flush), 32'd0);
  endtask

  task automatic cyc(input logic v, input logic [31:0] t, input logic s);
    redirect_valid  = v;
    redirect_target = t;
    stall_req       = s;
    #1;
    compare_all();
    @(posedge clk);
    if (rem > 0) rem--;
    else if (v) begin
      rem  = FC;
      mtgt = t;
      mcnt = (mcnt < 16'hFFFF) ? mcnt + 1 : mcnt;
    end
    @(negedge clk);
  endtask

  initial begin
    redirect_valid  = 1'b1;
    redirect_target = 32'hDEAD_BEEF;
    #3;
    compare_all();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h100, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h200, 1'b1);
    cyc(1'b1, 32'h300, 1'b1);
    cyc(1'b1, 32'h300, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(3) == 0, $urandom, $urandom_range(2) == 0);
    cyc(1'b1, 32'h400, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    rem  = 0;
    mtgt = '0;
    mcnt = 0;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b1);
    force dut.redirect_cnt_q = 16'hFFFC;
    #1 release dut.redirect_cnt_q;
    mcnt = 16'hFFFC;
    for (int i = 0; i < 20; i++) cyc(1'b1, $urandom, $urandom_range(1) == 1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("saturated", 32'(redirect_cnt), 32'h0000_FFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
